// File: rtl/alu_multibyte_sequencer.sv
// alu_multibyte_sequencer: walks the 8-bit ALU through a 1..MAX_BYTES byte operation,
// one ISSUE/CAPTURE pass per byte, chaining the shift carry and assembling the word result.
// Build option: define ALU_SEQ_ABORT_EN to add an Abort input that cancels an operation in flight.
`timescale 1ns/1ps
module alu_multibyte_sequencer #(
    parameter int MAX_BYTES = 4,
    parameter int CNT_W     = 3
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic                   Req,
`ifdef ALU_SEQ_ABORT_EN
    input  logic                   Abort,
`endif
    input  logic [3:0]             OpFirst,
    input  logic [3:0]             OpNext,
    input  logic [CNT_W-1:0]       NumBytes,
    input  logic                   MsbFirst,
    input  logic                   CarryIn,
    input  logic [8*MAX_BYTES-1:0] LhsWord,
    input  logic [8*MAX_BYTES-1:0] RhsWord,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Err,
    output logic [8*MAX_BYTES-1:0] ResultWord,
    output logic [4:0]             FlagsOut,
    output logic [3:0]             AluOp,
    output logic [7:0]             AluLhs,
    output logic [7:0]             AluRhs,
    output logic                   LCarryIn,
    output logic                   Alu_Assert,
    input  logic [7:0]             AluResult,
    input  logic [4:0]             AluFlags
);

    localparam logic [CNT_W:0] MAX_CNT = MAX_BYTES[CNT_W:0];

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        FINISH
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [CNT_W-1:0]         num_q, num_d;
    logic [3:0]               op_first_q, op_first_d;
    logic [3:0]               op_next_q, op_next_d;
    logic                     msb_first_q, msb_first_d;
    logic [8*MAX_BYTES-1:0]   lhs_q, lhs_d;
    logic [8*MAX_BYTES-1:0]   rhs_q, rhs_d;
    logic [8*MAX_BYTES-1:0]   result_q, result_d;
    logic                     zero_acc_q, zero_acc_d;
    logic [1:0]               sign_ov_q, sign_ov_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [4:0]               flags_q, flags_d;
    logic [3:0]               alu_op_q, alu_op_d;
    logic [7:0]               alu_lhs_q, alu_lhs_d;
    logic [7:0]               alu_rhs_q, alu_rhs_d;
    logic                     lcarry_q, lcarry_d;
    logic                     alu_assert_q, alu_assert_d;

    logic                     num_legal;
    logic [CNT_W-1:0]         accept_idx;
    logic [CNT_W-1:0]         cur_idx;
    logic [CNT_W-1:0]         count_inc;
    logic [CNT_W-1:0]         next_idx;
    logic                     zero_now;
    logic [1:0]               sign_ov_now;

    // Byte slot processed on pass 'cnt': counts up from the LSB, or down from the top byte.
    function automatic logic [CNT_W-1:0] byte_index(input logic [CNT_W-1:0] cnt,
                                                    input logic [CNT_W-1:0] num,
                                                    input logic             msb);
        byte_index = msb ? (num - CNT_W'(1) - cnt) : cnt;
    endfunction

    function automatic logic [7:0] byte_of(input logic [8*MAX_BYTES-1:0] word,
                                           input logic [CNT_W-1:0]       idx);
        byte_of = 8'h00;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (idx == CNT_W'(b)) begin
                byte_of = word[b*8 +: 8];
            end
        end
    endfunction

    assign num_legal   = (NumBytes != '0) && ({1'b0, NumBytes} <= MAX_CNT);
    assign accept_idx  = byte_index('0, NumBytes, MsbFirst);
    assign cur_idx     = byte_index(count_q, num_q, msb_first_q);
    assign count_inc   = count_q + CNT_W'(1);
    assign next_idx    = byte_index(count_inc, num_q, msb_first_q);
    assign zero_now    = zero_acc_q & AluFlags[2];
    assign sign_ov_now = (cur_idx == num_q - CNT_W'(1)) ? AluFlags[1:0] : sign_ov_q;

    // Next-state and next-output computation for the byte sequencing FSM.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        num_d        = num_q;
        op_first_d   = op_first_q;
        op_next_d    = op_next_q;
        msb_first_d  = msb_first_q;
        lhs_d        = lhs_q;
        rhs_d        = rhs_q;
        result_d     = result_q;
        zero_acc_d   = zero_acc_q;
        sign_ov_d    = sign_ov_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        flags_d      = flags_q;
        alu_op_d     = alu_op_q;
        alu_lhs_d    = alu_lhs_q;
        alu_rhs_d    = alu_rhs_q;
        lcarry_d     = lcarry_q;
        alu_assert_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (Req) begin
                    if (!num_legal) begin
                        err_d = 1'b1;
                    end else begin
                        num_d       = NumBytes;
                        op_first_d  = OpFirst;
                        op_next_d   = OpNext;
                        msb_first_d = MsbFirst;
                        lhs_d       = LhsWord;
                        rhs_d       = RhsWord;
                        count_d     = '0;
                        result_d    = '0;
                        zero_acc_d  = 1'b1;
                        sign_ov_d   = 2'b00;
                        busy_d      = 1'b1;
                        alu_op_d    = OpFirst;
                        alu_lhs_d   = byte_of(LhsWord, accept_idx);
                        alu_rhs_d   = byte_of(RhsWord, accept_idx);
                        lcarry_d    = CarryIn;
                        state_d     = ISSUE;
                    end
                end
            end

            ISSUE: begin
`ifdef ALU_SEQ_ABORT_EN
                if (Abort) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else
`endif
                begin
                    alu_assert_d = 1'b0;
                    state_d      = CAPTURE;
                end
            end

            CAPTURE: begin
`ifdef ALU_SEQ_ABORT_EN
                if (Abort) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else
`endif
                begin
                    for (int b = 0; b < MAX_BYTES; b++) begin
                        if (cur_idx == CNT_W'(b)) begin
                            result_d[b*8 +: 8] = AluResult;
                        end
                    end
                    zero_acc_d = zero_now;
                    sign_ov_d  = sign_ov_now;
                    count_d    = count_inc;
                    if (count_inc == num_q) begin
                        flags_d = {AluFlags[4], AluFlags[3], zero_now, sign_ov_now};
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        alu_op_d  = op_next_q;
                        alu_lhs_d = byte_of(lhs_q, next_idx);
                        alu_rhs_d = byte_of(rhs_q, next_idx);
                        lcarry_d  = AluFlags[4];
                        state_d   = ISSUE;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset releases the ALU bus drive immediately.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            num_q        <= '0;
            op_first_q   <= 4'h0;
            op_next_q    <= 4'h0;
            msb_first_q  <= 1'b0;
            lhs_q        <= '0;
            rhs_q        <= '0;
            result_q     <= '0;
            zero_acc_q   <= 1'b0;
            sign_ov_q    <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            flags_q      <= 5'b0;
            alu_op_q     <= 4'h0;
            alu_lhs_q    <= 8'h00;
            alu_rhs_q    <= 8'h00;
            lcarry_q     <= 1'b0;
            alu_assert_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            num_q        <= num_d;
            op_first_q   <= op_first_d;
            op_next_q    <= op_next_d;
            msb_first_q  <= msb_first_d;
            lhs_q        <= lhs_d;
            rhs_q        <= rhs_d;
            result_q     <= result_d;
            zero_acc_q   <= zero_acc_d;
            sign_ov_q    <= sign_ov_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            flags_q      <= flags_d;
            alu_op_q     <= alu_op_d;
            alu_lhs_q    <= alu_lhs_d;
            alu_rhs_q    <= alu_rhs_d;
            lcarry_q     <= lcarry_d;
            alu_assert_q <= alu_assert_d;
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Err        = err_q;
    assign ResultWord = result_q;
    assign FlagsOut   = flags_q;
    assign AluOp      = alu_op_q;
    assign AluLhs     = alu_lhs_q;
    assign AluRhs     = alu_rhs_q;
    assign LCarryIn   = lcarry_q;
    assign Alu_Assert = alu_assert_q;

endmodule

// File: doc/alu_multibyte_sequencer.md
Name: alu_multibyte_sequencer

Overview:
- Sequences the 8-bit ALU through multi-byte operations (16/24/32-bit add, subtract, shift, logic) one byte per ALU pass.
- Drives the ALU opcode, operand bytes, LCarryIn and the active-low result-assert line.
- Captures each result byte and chains carry between bytes.
- Sits between the pipeline control stage and the ALU; the requester sees one word-wide req/done transaction.

Parameters:
- MAX_BYTES, 4, maximum operand width in bytes (legal range 2..8).
- CNT_W, 3, width of NumBytes and the internal byte counter; must hold MAX_BYTES.

Ports:
- Clock  in  1  system clock, all state on rising edge.
- nReset  in  1  asynchronous active-low reset.
- Req  in  1  start request; sampled only in IDLE.
- OpFirst  in  4  ALU opcode for the first processed byte.
- OpNext  in  4  ALU opcode for subsequent bytes (carry-consuming variant, e.g. ADC/RCL).
- NumBytes  in  CNT_W  byte count; legal range 1..MAX_BYTES.
- MsbFirst  in  1  1 = process MSB byte first (right shifts), 0 = LSB first.
- CarryIn  in  1  LCarryIn value for the first byte.
- LhsWord  in  8*MAX_BYTES  left operand, byte 0 = LSB.
- RhsWord  in  8*MAX_BYTES  right operand.
- Busy  out  1  high from accept until Done.
- Done  out  1  one-cycle pulse when ResultWord/FlagsOut are valid.
- Err  out  1  one-cycle pulse on an illegal NumBytes.
- ResultWord  out  8*MAX_BYTES  assembled result; unused upper bytes zero.
- FlagsOut  out  5  {CarryL, CarryA, Zero, Sign, Overflow} aggregated.
- AluOp  out  4  to ALU opcode inputs.
- AluLhs  out  8  to ALU LHS bus.
- AluRhs  out  8  to ALU RHS bus.
- LCarryIn  out  1  to ALU shift carry input.
- Alu_Assert  out  1  active-low ALU result drive enable.
- AluResult  in  8  MainBus value while Alu_Assert is low.
- AluFlags  in  5  ALU flags {CarryL, CarryA, Zero, Sign, Overflow}.

Behaviour:
- Reset values: Busy=0, Done=0, Err=0, ResultWord=0, FlagsOut=0, AluOp=0, AluLhs=0, AluRhs=0, LCarryIn=0, Alu_Assert=1. State is IDLE.
- States and transitions:
  - IDLE: accept on Req=1.
    - If NumBytes==0 or NumBytes>MAX_BYTES: pulse Err next cycle and stay in IDLE.
    - Otherwise: latch all inputs, clear ResultWord, set Busy, go to ISSUE.
  - ISSUE (1 cycle): drive AluOp, AluLhs, AluRhs and LCarryIn for the current byte, then go to CAPTURE.
    - AluOp = OpFirst on the first byte, OpNext afterwards.
    - Byte index = count (LSB-first) or NumBytes-1-count (MsbFirst).
  - CAPTURE (1 cycle): hold the ALU inputs and drive Alu_Assert=0. On the closing edge:
    - write AluResult into the ResultWord byte slot;
    - register AluFlags as the carry source;
    - increment count.
    - If count reaches NumBytes go to FINISH, else go to ISSUE.
  - FINISH (1 cycle): Done=1, Busy=0, Alu_Assert=1; return to IDLE.
- Carry chaining: LCarryIn = CarryIn for the first byte. For later bytes it is the previous byte's CarryL; the ALU's internal adder carry follows OpNext.
- Flag aggregation:
  - Zero = AND of all byte Zero flags.
  - Sign and Overflow come from the MSB byte's pass.
  - CarryA and CarryL come from the last processed byte.
- Latency: Req accepted at edge 0 → Done high for cycle 2*NumBytes+1. A 2-byte op gives Done in cycle 5.
- Back-to-back: Req held high through FINISH is accepted on the cycle after Done (IDLE sampling); no requests are queued.
- Req while Busy is ignored. Inputs are latched, so requester changes mid-operation have no effect.
- nReset asserted mid-operation: all outputs return to reset values immediately, Alu_Assert releases to 1 asynchronously, and no Done is issued.
- Alu_Assert is low only in CAPTURE, so the block never drives MainBus contention outside its own passes.

Optional Feature:
- Macro: ALU_SEQ_ABORT_EN.
- When defined:
  - An extra input port, Abort (1 bit), is added.
  - Abort=1 in ISSUE or CAPTURE forces FINISH-free return to IDLE on the next edge: Alu_Assert=1, Busy=0, Done not pulsed, Err pulsed once, ResultWord holds the partial bytes.
  - Abort in IDLE is ignored.
- When undefined: no Abort port; every accepted operation runs to completion.

Test Plan:
- 16-bit add: LHS=0x12FF, RHS=0x0001, OpFirst=ADD, OpNext=ADC, NumBytes=2 → ResultWord=0x1300, Zero=0, CarryA=0, Done in cycle 5, Alu_Assert low exactly in cycles 2 and 4.
- 32-bit shift right: LHS=0x80000001, MsbFirst=1, CarryIn=0, NumBytes=4 → ResultWord=0x40000000, CarryL=1, Done in cycle 9.
- Zero aggregation: 16-bit subtract 0x0100-0x0100 → ResultWord=0x0000, Zero=1. Then 0x0100-0x00FF → 0x0001, Zero=0.
- Illegal count: NumBytes=0, then NumBytes=MAX_BYTES+1 → Err pulse each time, Busy stays 0, Alu_Assert stays 1, ResultWord unchanged.
- nReset pulsed during the CAPTURE of byte 1 of a 4-byte op → Alu_Assert=1 and Busy=0 immediately, no Done; a fresh request then completes normally.
- With ALU_SEQ_ABORT_EN: Abort in byte 2 ISSUE of a 4-byte op → Err pulse, no Done, ResultWord bytes 0-1 valid, bytes 2-3 zero.
